// File: rtl/rf_wb_arbiter_pkg.sv
// Shared register-file types plus the writeback arbiter request record.
package rf_wb_arbiter_pkg;

  localparam int XLEN          = 32;
  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_WB_MAX_REQ = 8;

  typedef logic [XLEN-1:0]          word_t;
  typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;

  localparam rf_addr_t X0                = '0;
  localparam word_t    WORD_ALL_ZEROS    = '0;
  localparam word_t    WORD_ALL_ONES     = '1;
  localparam word_t    WORD_MAX_UNSIGNED = '1;

  typedef struct packed {
    rf_addr_t addr;
    word_t    data;
  } rf_wb_req_t;

endpackage

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int REQ_IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [REQ_IDX_W-1:0] ptr,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [REQ_IDX_W-1:0] gnt_idx
);

  always_comb begin
    int  k;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      k = (int'(ptr) + off) % NUM_REQ;
      if (!found && req[k]) begin
        gnt[k]  = 1'b1;
        gnt_idx = REQ_IDX_W'(k);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ writers.
// Optional statistics counters enabled by defining RF_WB_ARB_STATS_EN.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int REQ_IDX_W = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  rf_addr_t             req_addr [NUM_REQ],
  input  word_t                req_data [NUM_REQ],
  input  logic                 rf_stall,
`ifdef RF_WB_ARB_STATS_EN
  input  logic                 stat_clr,
  output word_t                stat_grant_cnt [NUM_REQ],
  output word_t                stat_conflict_cnt,
`endif
  output logic                 rf_wr_en,
  output rf_addr_t             rf_wr_addr,
  output word_t                rf_wr_data,
  output logic [REQ_IDX_W-1:0] rf_wr_src
);

  logic [NUM_REQ-1:0]   gnt;
  logic [REQ_IDX_W-1:0] gnt_idx;
  logic                 xfer;
  rf_wb_req_t           sel_req;

  logic [REQ_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic                 wr_en_q, wr_en_d;
  rf_wb_req_t           wr_q, wr_d;
  logic [REQ_IDX_W-1:0] wr_src_q, wr_src_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .REQ_IDX_W(REQ_IDX_W)) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // No handshakes while held in reset: nothing would capture the write.
  assign req_ready = (rst_n && !rf_stall) ? gnt : '0;
  assign xfer      = |req_ready;

  always_comb begin
    sel_req  = '{addr: req_addr[gnt_idx], data: req_data[gnt_idx]};
    rr_ptr_d = rr_ptr_q;
    wr_en_d  = 1'b0;
    wr_d     = wr_q;
    wr_src_d = wr_src_q;
    if (xfer) begin
      wr_d     = sel_req;
      wr_src_d = gnt_idx;
      wr_en_d  = (sel_req.addr != X0);
      rr_ptr_d = (gnt_idx == REQ_IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      wr_en_q  <= 1'b0;
      wr_q     <= '{addr: X0, data: WORD_ALL_ZEROS};
      wr_src_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wr_en_q  <= wr_en_d;
      wr_q     <= wr_d;
      wr_src_q <= wr_src_d;
    end
  end

  assign rf_wr_en   = wr_en_q;
  assign rf_wr_addr = wr_q.addr;
  assign rf_wr_data = wr_q.data;
  assign rf_wr_src  = wr_src_q;

`ifdef RF_WB_ARB_STATS_EN
  word_t grant_cnt_q [NUM_REQ];
  word_t grant_cnt_d [NUM_REQ];
  word_t conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_cnt_d[i] = grant_cnt_q[i];
      if (stat_clr)
        grant_cnt_d[i] = '0;
      else if (req_ready[i] && grant_cnt_q[i] != WORD_MAX_UNSIGNED)
        grant_cnt_d[i] = grant_cnt_q[i] + 1'b1;
    end
    conflict_cnt_d = conflict_cnt_q;
    if (stat_clr)
      conflict_cnt_d = '0;
    else if (!rf_stall && $countones(req_valid) >= 2 && conflict_cnt_q != WORD_MAX_UNSIGNED)
      conflict_cnt_d = conflict_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
      conflict_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= grant_cnt_d[i];
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign stat_grant_cnt    = grant_cnt_q;
  assign stat_conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed vector bench for rf_wb_arbiter with NUM_REQ=2.
module tb_rf_wb_arbiter;
  import rf_wb_arbiter_pkg::*;

  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_ready;
  rf_addr_t     req_addr [N];
  word_t        req_data [N];
  logic         rf_stall;
  logic         rf_wr_en;
  rf_addr_t     rf_wr_addr;
  word_t        rf_wr_data;
  logic [0:0]   rf_wr_src;
`ifdef RF_WB_ARB_STATS_EN
  logic         stat_clr;
  word_t        stat_grant_cnt [N];
  word_t        stat_conflict_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  word_t shadow_rf [32];

  always #5 clk = ~clk;

  rf_wb_arbiter #(.NUM_REQ(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .rf_stall   (rf_stall),
`ifdef RF_WB_ARB_STATS_EN
    .stat_clr          (stat_clr),
    .stat_grant_cnt    (stat_grant_cnt),
    .stat_conflict_cnt (stat_conflict_cnt),
`endif
    .rf_wr_en   (rf_wr_en),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .rf_wr_src  (rf_wr_src)
  );

  always @(posedge clk) if (rf_wr_en) shadow_rf[rf_wr_addr] <= rf_wr_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] v;
    logic       stall;
    rf_addr_t   a0; word_t d0;
    rf_addr_t   a1; word_t d1;
    logic [1:0] rdy;
    logic       en;
    logic       chk_ad;
    rf_addr_t   addr; word_t data; logic src;
  } vec_t;

  function automatic vec_t mk(logic [1:0] v, logic st, rf_addr_t a0, word_t d0,
                              rf_addr_t a1, word_t d1, logic [1:0] rdy, logic en,
                              logic ca, rf_addr_t ad, word_t da, logic src);
    vec_t r;
    r.v = v; r.stall = st; r.a0 = a0; r.d0 = d0; r.a1 = a1; r.d1 = d1;
    r.rdy = rdy; r.en = en; r.chk_ad = ca; r.addr = ad; r.data = da; r.src = src;
    return r;
  endfunction

  vec_t vecs [16];

  initial begin
    vecs[0]  = mk(2'b11, 0, 5, 32'h1111_1111, 6, 32'h2222_2222, 2'b01, 1, 1, 5, 32'h1111_1111, 0);
    vecs[1]  = mk(2'b11, 0, 5, 32'h1111_1111, 6, 32'h2222_2222, 2'b10, 1, 1, 6, 32'h2222_2222, 1);
    vecs[2]  = mk(2'b11, 0, 5, 32'h1111_1111, 6, 32'h2222_2222, 2'b01, 1, 1, 5, 32'h1111_1111, 0);
    vecs[3]  = mk(2'b11, 0, 5, 32'h1111_1111, 6, 32'h2222_2222, 2'b10, 1, 1, 6, 32'h2222_2222, 1);
    vecs[4]  = mk(2'b10, 0, 5, 32'h1111_1111, 0, 32'hdead_beef, 2'b10, 0, 1, 0, 32'hdead_beef, 1);
    vecs[5]  = mk(2'b11, 0, 5, 32'h1111_1111, 6, 32'h2222_2222, 2'b01, 1, 1, 5, 32'h1111_1111, 0);
    vecs[6]  = mk(2'b11, 1, 5, 32'h1111_1111, 6, 32'h2222_2222, 2'b00, 0, 0, 0, 0, 0);
    vecs[7]  = mk(2'b11, 1, 5, 32'h1111_1111, 6, 32'h2222_2222, 2'b00, 0, 0, 0, 0, 0);
    vecs[8]  = mk(2'b11, 1, 5, 32'h1111_1111, 6, 32'h2222_2222, 2'b00, 0, 0, 0, 0, 0);
    vecs[9]  = mk(2'b11, 0, 5, 32'h1111_1111, 6, 32'h2222_2222, 2'b10, 1, 1, 6, 32'h2222_2222, 1);
    vecs[10] = mk(2'b11, 0, 7, 32'h0000_0001, 7, WORD_ALL_ONES, 2'b01, 1, 1, 7, 32'h0000_0001, 0);
    vecs[11] = mk(2'b11, 0, 7, 32'h0000_0001, 7, WORD_ALL_ONES, 2'b10, 1, 1, 7, WORD_ALL_ONES, 1);
    vecs[12] = mk(2'b00, 0, 1, 32'h0,         2, 32'h0,         2'b00, 0, 0, 0, 0, 0);
    vecs[13] = mk(2'b10, 0, 1, 32'h0,         9, 32'h0000_0003, 2'b10, 1, 1, 9, 32'h0000_0003, 1);
    vecs[14] = mk(2'b01, 0, 3, 32'h0000_00ab, 9, 32'h0000_0003, 2'b01, 1, 1, 3, 32'h0000_00ab, 0);
    vecs[15] = mk(2'b01, 0, 3, 32'h0000_00ac, 9, 32'h0000_0003, 2'b01, 1, 1, 3, 32'h0000_00ac, 0);

    rst_n = 1'b0; rf_stall = 1'b0; req_valid = 2'b11;
    req_addr[0] = 5; req_data[0] = 32'h1111_1111;
    req_addr[1] = 6; req_data[1] = 32'h2222_2222;
`ifdef RF_WB_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en",    64'(rf_wr_en),   64'd0);
    chk("rst_addr",  64'(rf_wr_addr), 64'd0);
    chk("rst_data",  64'(rf_wr_data), 64'd0);
    chk("rst_src",   64'(rf_wr_src),  64'd0);
    chk("rst_ready", 64'(req_ready),  64'd0);
`ifdef RF_WB_ARB_STATS_EN
    chk("rst_conf",  64'(stat_conflict_cnt), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      if (i != 0) @(negedge clk);
      req_valid   = vecs[i].v;
      rf_stall    = vecs[i].stall;
      req_addr[0] = vecs[i].a0; req_data[0] = vecs[i].d0;
      req_addr[1] = vecs[i].a1; req_data[1] = vecs[i].d1;
      #1;
      chk($sformatf("v%0d_ready", i), 64'(req_ready), 64'(vecs[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_en", i), 64'(rf_wr_en), 64'(vecs[i].en));
      if (vecs[i].chk_ad) begin
        chk($sformatf("v%0d_addr", i), 64'(rf_wr_addr), 64'(vecs[i].addr));
        chk($sformatf("v%0d_data", i), 64'(rf_wr_data), 64'(vecs[i].data));
        chk($sformatf("v%0d_src", i),  64'(rf_wr_src),  64'(vecs[i].src));
      end
    end
    chk("x7_final", 64'(shadow_rf[7]), 64'(WORD_ALL_ONES));

    // Reset in the middle of a write: outputs drop without waiting for a clock.
    @(negedge clk);
    req_valid = 2'b11;
    req_addr[0] = 5; req_data[0] = 32'h1111_1111;
    req_addr[1] = 6; req_data[1] = 32'h2222_2222;
    @(posedge clk);
    #1;
    chk("mid_en_before", 64'(rf_wr_en),  64'd1);
    chk("mid_src_before", 64'(rf_wr_src), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_en",    64'(rf_wr_en),   64'd0);
    chk("mid_addr",  64'(rf_wr_addr), 64'd0);
    chk("mid_data",  64'(rf_wr_data), 64'd0);
    chk("mid_ready", 64'(req_ready),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 64'(req_ready), 64'b01);

`ifdef RF_WB_ARB_STATS_EN
    repeat (10) @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    chk("stat_conf",   64'(stat_conflict_cnt), 64'd10);
    chk("stat_grant0", 64'(stat_grant_cnt[0]), 64'd5);
    chk("stat_grant1", 64'(stat_grant_cnt[1]), 64'd5);
    stat_clr = 1'b1;
    req_valid = 2'b11;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    chk("clr_conf",   64'(stat_conflict_cnt), 64'd0);
    chk("clr_grant0", 64'(stat_grant_cnt[0]), 64'd0);
    chk("clr_grant1", 64'(stat_grant_cnt[1]), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Shares the register file's single write port between NUM_REQ writeback requesters, for example the ALU, the load unit and CSR/misc.
- Uses a valid/ready handshake per requester.
- Grants round-robin.
- Registers the winning write into a one-stage output register that drives the register file.
- Writes to X0 are accepted and silently dropped.

Parameters:
NUM_REQ, 2, number of writeback requesters; legal range 2..RF_WB_MAX_REQ (8)
REQ_IDX_W, $clog2(NUM_REQ), width of requester index; derived, do not override

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  requester i has a write pending
req_ready  out  NUM_REQ  requester i granted this cycle (one-hot or zero)
req_addr  in  NUM_REQ x RF_ADDR_WIDTH  destination register per requester (rf_addr_t)
req_data  in  NUM_REQ x XLEN  write data per requester (word_t)
rf_stall  in  1  write port unavailable this cycle; no grants
rf_wr_en  out  1  register-file write enable
rf_wr_addr  out  RF_ADDR_WIDTH  register-file write address
rf_wr_data  out  XLEN  register-file write data
rf_wr_src  out  REQ_IDX_W  index of requester that produced current write

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: rf_wr_en=0, rf_wr_addr=X0, rf_wr_data=WORD_ALL_ZEROS, rf_wr_src=0, rr_ptr=0. Asserting rst_n low mid-operation forces all of these immediately; an in-flight grant is lost.
- req_ready is combinational from req_valid, rr_ptr and rf_stall.
- Grant selection: the first valid requester scanning rr_ptr, rr_ptr+1, ... (mod NUM_REQ). At most one req_ready is high per cycle.
- rf_stall=1: all req_ready=0; on the next edge rf_wr_en<=0 and rr_ptr is unchanged.
- Transfer: occurs when req_valid[g] && req_ready[g]. On that edge:
  - rf_wr_addr<=req_addr[g]
  - rf_wr_data<=req_data[g]
  - rf_wr_src<=g
  - rf_wr_en<=(req_addr[g]!=X0)
  - rr_ptr<=(g+1) mod NUM_REQ, wrapping NUM_REQ-1 -> 0
- Latency: exactly 1 cycle from accepted handshake to rf_wr_en.
- No transfer in a cycle: rf_wr_en<=0. Address and data hold their last values (don't-care).
- X0 writes: the handshake completes and rr_ptr advances, but rf_wr_en stays 0.
- Requester obligations: hold valid, addr and data stable until ready. Valid may not drop without a transfer. The arbiter never depends on this for its own correctness.
- Same destination from multiple requesters: served in round-robin order, one per cycle. The later write wins in the register file. No merging.
- Throughput: one write per cycle. A continuously valid requester is granted at least once every NUM_REQ cycles (no starvation).

Optional Feature:
RF_WB_ARB_STATS_EN
- Defined: adds input stat_clr (1) and outputs stat_grant_cnt (NUM_REQ x XLEN) and stat_conflict_cnt (XLEN).
  - stat_grant_cnt[i] increments on each transfer from requester i, including X0 writes.
  - stat_conflict_cnt increments on each cycle with at least 2 req_valid high and rf_stall=0.
  - Both counters saturate at WORD_MAX_UNSIGNED.
  - stat_clr synchronously zeroes all counters and has priority over increments.
  - Reset value 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package gets:
  - RF_WB_MAX_REQ=8
  - rf_wb_req_t struct {rf_addr_t addr; word_t data}
- rf_wb_arbiter reuses existing word_t, rf_addr_t, X0, XLEN and RF_ADDR_WIDTH.
- One sub-module, rr_arbiter: combinational round-robin grant from a request vector and pointer, returning a one-hot grant and encoded index. It is parameterized by NUM_REQ and reusable elsewhere.
- rf_wb_arbiter keeps the pointer register and output stage.

Test Plan:
1. Reset: hold rst_n=0 with all req_valid=1 -> rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, req_ready=0. Release -> first grant goes to req0.
2. Round-robin, NUM_REQ=2: both valid for 4 cycles, req0 addr 5 data 32'h1111_1111, req1 addr 6 data 32'h2222_2222 -> grants 0,1,0,1. rf_wr_en each cycle one cycle later with matching addr/data/src.
3. X0 drop: req1 valid, addr 0, data 32'hdead_beef -> req_ready[1]=1, next cycle rf_wr_en=0. Next grant with both valid goes to req0.
4. Stall: both valid, rf_stall=1 for 3 cycles -> req_ready=0, rf_wr_en=0, rr_ptr unchanged. Stall drop -> grant resumes at the saved pointer.
5. Same address conflict: req0 addr 7 data 32'h0000_0001, req1 addr 7 data WORD_ALL_ONES, both valid -> two consecutive writes to x7, final x7=WORD_ALL_ONES.
6. Reset mid-operation, plus stats: assert rst_n low one cycle after a grant -> rf_wr_en drops immediately. With RF_WB_ARB_STATS_EN, 10 dual-valid cycles -> stat_conflict_cnt=10, stat_grant_cnt={5,5}; stat_clr -> all 0.
